// File: rtl/accel_pkg.sv
// accel_pkg: shared types and constants for the accelerator dispatcher.
//   st_e           - dispatcher FSM state encoding
//   ENG_HASH/ENC/DEC - engine select codes driven on eng_sel
//   ACCEL_DATA_W   - default operand/result width
package accel_pkg;

  localparam int ACCEL_DATA_W = 16;

  localparam logic [1:0] ENG_HASH = 2'd0;
  localparam logic [1:0] ENG_ENC  = 2'd1;
  localparam logic [1:0] ENG_DEC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } st_e;

endpackage

// File: rtl/accel_dispatch.sv
// accel_dispatch: hands one hash/encrypt/decrypt instruction at a time to a
// shared engine, stalls the CPU front end while it is in flight, and writes
// the engine result back to the register file.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   H_int, E_int, D_int       requests from the decoder (priority H > E > D)
//   op_data, op_dst           source operand / destination register
//   stall                     holds the front end (combinational)
//   eng_req/eng_sel/eng_data  engine request handshake and operand
//   eng_ack/eng_done/eng_result engine acceptance, completion, result
//   wb_en/wb_reg/wb_data      one-cycle register writeback
//   err                       sticky: multiple requests at once, or timeout
//
// Build option: define ACCEL_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYC cycles; a timeout writes back all-ones and sets err.
module accel_dispatch
  import accel_pkg::*;
#(
  parameter int DATA_W      = ACCEL_DATA_W,
  parameter int REG_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              H_int,
  input  logic              E_int,
  input  logic              D_int,
  input  logic [DATA_W-1:0] op_data,
  input  logic [REG_W-1:0]  op_dst,
  output logic              stall,
  output logic              eng_req,
  output logic [1:0]        eng_sel,
  output logic [DATA_W-1:0] eng_data,
  input  logic              eng_ack,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_result,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  st_e  r_state, w_nxt;
  logic w_any, w_multi;

  assign w_any   = H_int | E_int | D_int;
  assign w_multi = (H_int & E_int) | (H_int & D_int) | (E_int & D_int);

`ifdef ACCEL_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = TIMEOUT_CYC[7:0];
  logic [7:0] r_to_cnt;
  logic       w_to;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    stall   = 1'b0;
    eng_req = 1'b0;
    wb_en   = 1'b0;
`ifdef ACCEL_TIMEOUT_EN
    w_to    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_any) begin
          stall = 1'b1;
          w_nxt = ISSUE;
        end
      end
      ISSUE: begin
        stall   = 1'b1;
        eng_req = 1'b1;
        if (eng_ack) w_nxt = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        // eng_done takes precedence over a timeout in the same cycle
        if (eng_done) w_nxt = WB;
`ifdef ACCEL_TIMEOUT_EN
        else if (r_to_cnt == TO_LIM) begin
          w_to  = 1'b1;
          w_nxt = WB;
        end
`endif
      end
      WB: begin
        wb_en = 1'b1;
        w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
    // the front end must never be held while the block is in reset
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eng_sel  <= '0;
      eng_data <= '0;
      wb_reg   <= '0;
      wb_data  <= '0;
      err      <= 1'b0;
`ifdef ACCEL_TIMEOUT_EN
      r_to_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            eng_sel  <= H_int ? ENG_HASH : (E_int ? ENG_ENC : ENG_DEC);
            eng_data <= op_data;
            wb_reg   <= op_dst;
            if (w_multi) err <= 1'b1;
          end
        end
`ifdef ACCEL_TIMEOUT_EN
        // holding the counter at zero through ISSUE clears it on WAIT entry
        ISSUE: r_to_cnt <= '0;
`endif
        WAIT: begin
          if (eng_done) wb_data <= eng_result;
`ifdef ACCEL_TIMEOUT_EN
          else if (w_to) begin
            wb_data <= '1;
            err     <= 1'b1;
          end
          r_to_cnt <= r_to_cnt + 8'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_dispatch.sv
// tb_accel_dispatch: randomized and directed transactions against a
// transaction-level model (request winner, sticky error, cycle timeline
// derived from ack/done delays).
module tb_accel_dispatch;
  localparam int DW = 16;
  localparam int RW = 4;
`ifdef ACCEL_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          H_int, E_int, D_int;
  logic [DW-1:0] op_data;
  logic [RW-1:0] op_dst;
  logic          stall, eng_req, eng_ack, eng_done, wb_en, err;
  logic [1:0]    eng_sel;
  logic [DW-1:0] eng_data, eng_result, wb_data;
  logic [RW-1:0] wb_reg;

  int n_cmp = 0;
  int n_mis = 0;
  bit m_err;

  always #5 clk = ~clk;

  accel_dispatch #(.DATA_W(DW), .REG_W(RW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .H_int(H_int), .E_int(E_int), .D_int(D_int),
    .op_data(op_data), .op_dst(op_dst),
    .stall(stall),
    .eng_req(eng_req), .eng_sel(eng_sel), .eng_data(eng_data),
    .eng_ack(eng_ack), .eng_done(eng_done), .eng_result(eng_result),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic noise_req();
    {H_int, E_int, D_int} = 3'($urandom);
    op_data = 16'($urandom);
    op_dst  = 4'($urandom);
  endtask

  // hed = {H,E,D}; a = ISSUE cycles before ack; d = WAIT cycles before done,
  // d < 0 means the engine never answers (timeout builds only).
  task automatic run_txn(input logic [2:0] hed, input logic [DW-1:0] dat,
                         input logic [RW-1:0] dst, input int a, input int d,
                         input logic [DW-1:0] res);
    logic [1:0]    e_sel;
    logic [DW-1:0] e_wb;
    int            last;
    e_sel = hed[2] ? 2'd0 : (hed[1] ? 2'd1 : 2'd2);
    if (int'(hed[2]) + int'(hed[1]) + int'(hed[0]) > 1) m_err = 1'b1;
    last = (d < 0) ? TO : d;
    e_wb = res;
    if (d < 0) begin
      e_wb  = '1;
      m_err = 1'b1;
    end
    // cycle 0: request seen in IDLE
    @(negedge clk);
    {H_int, E_int, D_int} = hed;
    op_data = dat; op_dst = dst;
    eng_ack = 1'b0; eng_done = 1'b0; eng_result = 16'($urandom);
    #1;
    chk("req_stall", stall, 1'b1);
    chk("req_noeng", eng_req, 1'b0);
    // ISSUE: done pulses here must be ignored
    for (int i = 0; i <= a; i++) begin
      @(negedge clk);
      noise_req();
      eng_ack    = (i == a);
      eng_done   = 1'($urandom);
      eng_result = 16'($urandom);
      #1;
      chk("iss_req", eng_req, 1'b1);
      chk("iss_sel", eng_sel, e_sel);
      chk("iss_data", eng_data, dat);
      chk("iss_stall", stall, 1'b1);
      chk("iss_nowb", wb_en, 1'b0);
    end
    // WAIT
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      noise_req();
      eng_ack    = 1'($urandom);
      eng_done   = (d >= 0) && (j == d);
      eng_result = eng_done ? res : 16'($urandom);
      #1;
      chk("wt_req", eng_req, 1'b0);
      chk("wt_stall", stall, 1'b1);
      chk("wt_nowb", wb_en, 1'b0);
    end
    // WB
    @(negedge clk);
    noise_req();
    eng_ack = 1'b0; eng_done = 1'($urandom);
    #1;
    chk("wb_en", wb_en, 1'b1);
    chk("wb_reg", wb_reg, dst);
    chk("wb_data", wb_data, e_wb);
    chk("wb_stall", stall, 1'b0);
    chk("wb_err", err, m_err);
    // back to IDLE, quiet
    @(negedge clk);
    {H_int, E_int, D_int} = 3'b000;
    eng_done = 1'b0;
    #1;
    chk("idl_wb", wb_en, 1'b0);
    chk("idl_stall", stall, 1'b0);
    chk("idl_req", eng_req, 1'b0);
    chk("idl_err", err, m_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    {H_int, E_int, D_int} = 3'b111;
    eng_ack = 1'b0; eng_done = 1'b0;
    #1;
    chk("rst_stall", stall, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_stall2", stall, 1'b0);
    chk("rst_req", eng_req, 1'b0);
    chk("rst_sel", eng_sel, 2'd0);
    chk("rst_data", eng_data, 16'd0);
    chk("rst_wbreg", wb_reg, 4'd0);
    chk("rst_wbdata", wb_data, 16'd0);
    chk("rst_wben", wb_en, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    {H_int, E_int, D_int} = 3'b000;
    m_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {H_int, E_int, D_int} = 3'b000;
    op_data = '0; op_dst = '0;
    eng_ack = 1'b0; eng_done = 1'b0; eng_result = '0;
    m_err = 1'b0;
    do_reset();

    // minimum latency, encrypt
    run_txn(3'b010, 16'h1234, 4'd5, 0, 0, 16'hBEEF);
    // ack withheld 4 cycles, decrypt
    run_txn(3'b001, 16'h00A5, 4'd9, 4, 1, 16'h5A5A);
    // H and D together: H wins, err sticks
    run_txn(3'b101, 16'h7777, 4'd2, 0, 0, 16'h1111);
    run_txn(3'b100, 16'h0001, 4'd3, 1, 2, 16'h2222);

    // reset while in WAIT, then a stray eng_done
    do_reset();
    @(negedge clk); {H_int, E_int, D_int} = 3'b100; op_dst = 4'd7;
    @(negedge clk); {H_int, E_int, D_int} = 3'b000; eng_ack = 1'b1;
    @(negedge clk); eng_ack = 1'b0;
    #1; chk("rw_inwait", stall, 1'b1);
    @(negedge clk); rst = 1'b1; H_int = 1'b1;
    #1; chk("rw_rststall", stall, 1'b0);
    @(negedge clk); rst = 1'b0; H_int = 1'b0; eng_done = 1'b1; eng_result = 16'hDEAD;
    #1;
    chk("rw_nowb", wb_en, 1'b0);
    chk("rw_stall", stall, 1'b0);
    chk("rw_req", eng_req, 1'b0);
    @(negedge clk); eng_done = 1'b0;
    #1;
    chk("rw_nowb2", wb_en, 1'b0);
    chk("rw_wbdata", wb_data, 16'd0);
    m_err = 1'b0;

`ifdef ACCEL_TIMEOUT_EN
    // done in the timeout cycle wins, then a real timeout
    run_txn(3'b010, 16'h4321, 4'd6, 0, TO, 16'hCAFE);
    run_txn(3'b001, 16'h8888, 4'd4, 1, -1, 16'h0000);
`endif

    for (int k = 0; k < 40; k++) begin
      run_txn(3'($urandom_range(1, 7)), 16'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/accel_dispatch.md
ACCEL_DISPATCH -- requirements
Module: accel_dispatch

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the operand/result width.
REQ-002 SHALL have parameter REG_W, default 4, the destination register index width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, the WAIT-state cycle limit, used only when ACCEL_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-006 SHALL have ports H_int, E_int and D_int, input, 1 each, the hash, encrypt and decrypt requests from the control decoder.
REQ-007 SHALL have port op_data, input, DATA_W, the source operand of the requesting instruction.
REQ-008 SHALL have port op_dst, input, REG_W, the destination register of the requesting instruction.
REQ-009 SHALL have port stall, output, 1, which holds the CPU front end.
REQ-010 SHALL have ports eng_req (output, 1), eng_sel (output, 2) and eng_data (output, DATA_W), the engine request, engine select (H=0, E=1, D=2) and operand to the engine.
REQ-011 SHALL have ports eng_ack (input, 1), eng_done (input, 1) and eng_result (input, DATA_W), the engine acceptance, completion and result.
REQ-012 SHALL have ports wb_en (output, 1), wb_reg (output, REG_W) and wb_data (output, DATA_W), the register-file writeback.
REQ-013 SHALL have port err, output, 1, a sticky error flag.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT and WB.
REQ-015 In IDLE, when any of H_int, E_int or D_int is 1: latch op_data and op_dst, latch eng_sel with priority H>E>D, and go to ISSUE.
REQ-016 SHALL set err when more than one of H_int, E_int and D_int is 1 in IDLE; the request still proceeds with the priority winner.
REQ-017 SHALL drive stall = (IDLE and any request) or ISSUE or WAIT, combinationally, so stall is high in the same cycle the request is first seen.
REQ-018 In ISSUE, SHALL hold eng_req=1 with a stable eng_sel and eng_data until eng_ack=1, then go to WAIT; eng_req SHALL be 0 in every other state.
REQ-019 In WAIT, on eng_done=1, SHALL capture eng_result into wb_data and go to WB; eng_done SHALL be ignored in every other state.
REQ-020 In WB, SHALL drive wb_en=1 for exactly one cycle with wb_reg equal to the latched op_dst, drive stall=0, and go to IDLE.
REQ-021 SHALL ignore requests in ISSUE, WAIT and WB (the decoder output is held by the stall, or retiring in WB).
REQ-022 Minimum latency, with eng_ack in cycle 1 and eng_done in cycle 2 after the request in cycle 0: wb_en in cycle 3, stall high in cycles 0-2.
REQ-023 SHALL clear err only by rst.

Reset
REQ-024 While rst=1 at a clock edge: state=IDLE, eng_req=0, eng_sel=0, eng_data=0, wb_en=0, wb_reg=0, wb_data=0, err=0, timeout counter=0.
REQ-025 During reset, stall SHALL be 0 regardless of request inputs.
REQ-026 Reset in ISSUE or WAIT SHALL abandon the operation with no writeback; a later eng_done SHALL be ignored.

Configuration
REQ-027 With ACCEL_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-028 With ACCEL_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYC with no eng_done: go to WB with wb_data = all-ones and set err.
REQ-029 With ACCEL_TIMEOUT_EN defined, if eng_done and the timeout occur in the same cycle, eng_done SHALL win.
REQ-030 Without ACCEL_TIMEOUT_EN: no counter exists, and WAIT SHALL last indefinitely until eng_done.

Structure
REQ-031 Package accel_pkg SHALL hold the FSM state enum, the engine select constants (ENG_HASH=0, ENG_ENC=1, ENG_DEC=2) and the DATA_W default.
REQ-032 SHALL be a single module with no sub-modules; the timeout counter SHALL be inline.

Verification
REQ-033 E_int=1, op_data=0x1234, op_dst=5; eng_ack in cycle 1; eng_done with eng_result=0xBEEF in cycle 2 -> eng_sel=1 and eng_data=0x1234 in cycle 1; wb_en=1, wb_reg=5, wb_data=0xBEEF in cycle 3; err=0.
REQ-034 H_int=1 and D_int=1 together -> eng_sel=0; err=1 and stays 1 after completion.
REQ-035 D_int=1 with eng_ack withheld 4 cycles -> eng_req, eng_sel=2 and stall held for 4 cycles; eng_done pulsed during ISSUE is ignored.
REQ-036 rst asserted in WAIT, then eng_done=1 -> no wb_en; state IDLE; stall=0.
REQ-037 ACCEL_TIMEOUT_EN defined with TIMEOUT_CYC=10 and no eng_done -> WB with wb_data=0xFFFF and err=1; eng_done in the timeout cycle -> engine result written and err=0.
